piso_shift_register_32bit: RTL

Parallel-in, serial-out shift register with a load handshake: accepts a 32-bit word and emits it one bit per enabled clock, MSB first. It is the transmit end of the serial bit path whose receive end is the 32-bit right-shift register. In that register each new bit enters at Q[0] and moves upward, so the first bit transmitted ends up in Q[31]. Driving the receiver's D_in from D_out and its en from out_valid & en reconstructs the loaded word in its Q after 32 beats.

---
 rtl/piso_shift_register_32bit_if.sv | 38 +++
 rtl/piso_shift_register_32bit.sv | 75 +++++++
 2 files changed

// File: rtl/piso_shift_register_32bit_if.sv
// rtl/piso_shift_register_32bit_if.sv - load handshake and serial output bundle for the 32-bit PISO
// Signals:
//   load_valid / load_ready / D_par : parallel word handshake into the shifter
//   en                               : shift enable, shared with the downstream receiver
//   D_out / out_valid / last / done  : serial bit stream and word-boundary markers
// Modports: master drives the load side and en, slave is the shifter itself.
interface piso_shift_register_32bit_if;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] D_par;
    logic        en;
    logic        D_out;
    logic        out_valid;
    logic        last;
    logic        done;

    modport master (
        output load_valid,
        output D_par,
        output en,
        input  load_ready,
        input  D_out,
        input  out_valid,
        input  last,
        input  done
    );

    modport slave (
        input  load_valid,
        input  D_par,
        input  en,
        output load_ready,
        output D_out,
        output out_valid,
        output last,
        output done
    );
endinterface

// File: rtl/piso_shift_register_32bit.sv
// rtl/piso_shift_register_32bit.sv - 32-bit parallel-in serial-out shifter, MSB first, with load handshake
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of piso_shift_register_32bit_if
//           (load_valid/load_ready/D_par in, en in, D_out/out_valid/last/done out)
module piso_shift_register_32bit (
    input  logic                             clk,
    input  logic                             rst_n,
    piso_shift_register_32bit_if.slave       bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] shreg_q, shreg_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic        done_q,  done_d;

    logic        beat;
    logic        final_beat;
    logic        load;

    assign beat       = (state_q == SHIFT) && bus.en;
    assign final_beat = beat && (cnt_q == 5'd31);

    // Ready combinationally on the final beat so a new word can follow
    // the previous one with no idle bit between them.
    assign bus.load_ready = (state_q == IDLE) || final_beat;
    assign load           = bus.load_valid && bus.load_ready;

    // Outputs decode registered state only; en does not reach them.
    assign bus.out_valid = (state_q == SHIFT);
    assign bus.D_out     = (state_q == SHIFT) ? shreg_q[31] : 1'b0;
    assign bus.last      = (state_q == SHIFT) && (cnt_q == 5'd31);
    assign bus.done      = done_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = final_beat;
        if (load) begin
            // Covers both an idle load and a reload on the final beat.
            shreg_d = bus.D_par;
            cnt_d   = 5'd0;
            state_d = SHIFT;
        end else if (final_beat) begin
            shreg_d = 32'h0;
            cnt_d   = 5'd0;
            state_d = IDLE;
        end else if (beat) begin
            shreg_d = {shreg_q[30:0], 1'b0};
            cnt_d   = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= 32'h0;
            cnt_q   <= 5'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule
